// File: rtl/alu_operand_stage.sv
// Decode-to-execute operand stage for the RISC-V Alu.
// Two-entry skid buffer. Writeback values are forwarded into a beat when it is
// captured, and held beats keep watching writeback so the operands they present
// are always current.
module alu_operand_stage #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_rs1_addr,
  input  logic [WIDTH-1:0] in_rs1_data,
  input  logic [AW-1:0]    in_rs2_addr,
  input  logic [WIDTH-1:0] in_rs2_data,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_use_imm,
  input  logic [1:0]       in_sel,
  input  logic [AW-1:0]    in_rd,
  input  logic             in_reg_write,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [1:0]       out_sel,
  output logic [AW-1:0]    out_rd,
  output logic             out_reg_write
);

  typedef struct packed {
    logic [AW-1:0]    rs1Addr;
    logic [WIDTH-1:0] op1;
    logic [AW-1:0]    rs2Addr;
    logic [WIDTH-1:0] op2;
    logic             useImm;
    logic [1:0]       sel;
    logic [AW-1:0]    rd;
    logic             regWrite;
  } entry_t;

  // The head entry sits in r_head; r_tail only holds a beat when r_count is 2.
  logic [1:0] r_count;
  entry_t     r_head;
  entry_t     r_tail;

  logic [1:0] w_countNext;
  entry_t     w_headNext;
  entry_t     w_tailNext;
  entry_t     w_headSnoop;
  entry_t     w_tailSnoop;
  entry_t     w_capture;
  logic       w_wbLive;
  logic       w_accept;
  logic       w_pop;

  // x0 is hardwired to zero, so a writeback to it must never be forwarded.
  assign w_wbLive = wb_en && (wb_addr != '0);

  // Handshakes depend only on registered state and flush, never on out_ready.
  assign in_ready  = (r_count != 2'd2) && !flush;
  assign out_valid = (r_count != 2'd0);
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign out_data1     = r_head.op1;
  assign out_data2     = r_head.op2;
  assign out_sel       = r_head.sel;
  assign out_rd        = r_head.rd;
  assign out_reg_write = r_head.regWrite;

  // Build the incoming entry, taking same-cycle writeback in place of stale regfile data.
  always_comb begin
    w_capture          = '0;
    w_capture.rs1Addr  = in_rs1_addr;
    w_capture.rs2Addr  = in_rs2_addr;
    w_capture.useImm   = in_use_imm;
    w_capture.sel      = in_sel;
    w_capture.rd       = in_rd;
    w_capture.regWrite = in_reg_write;
    w_capture.op1      = (w_wbLive && (wb_addr == in_rs1_addr)) ? wb_data : in_rs1_data;
    if (in_use_imm) begin
      w_capture.op2 = in_imm;
    end else begin
      w_capture.op2 = (w_wbLive && (wb_addr == in_rs2_addr)) ? wb_data : in_rs2_data;
    end
  end

  // Held entries pick up writebacks to their sources; an immediate op2 is left alone.
  always_comb begin
    w_headSnoop = r_head;
    w_tailSnoop = r_tail;
    if (w_wbLive && (wb_addr == r_head.rs1Addr)) begin
      w_headSnoop.op1 = wb_data;
    end
    if (w_wbLive && !r_head.useImm && (wb_addr == r_head.rs2Addr)) begin
      w_headSnoop.op2 = wb_data;
    end
    if (w_wbLive && (wb_addr == r_tail.rs1Addr)) begin
      w_tailSnoop.op1 = wb_data;
    end
    if (w_wbLive && !r_tail.useImm && (wb_addr == r_tail.rs2Addr)) begin
      w_tailSnoop.op2 = wb_data;
    end
  end

  // Occupancy and entry movement: pops shift the tail forward, accepts fill the first free slot.
  always_comb begin
    w_countNext = r_count;
    w_headNext  = w_headSnoop;
    w_tailNext  = w_tailSnoop;
    if (flush) begin
      w_countNext = 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_accept) begin
            w_headNext  = w_capture;
            w_countNext = 2'd1;
          end
        end
        2'd1: begin
          if (w_accept && w_pop) begin
            w_headNext = w_capture;
          end else if (w_pop) begin
            w_countNext = 2'd0;
          end else if (w_accept) begin
            w_tailNext  = w_capture;
            w_countNext = 2'd2;
          end
        end
        2'd2: begin
          if (w_pop) begin
            w_headNext  = w_tailSnoop;
            w_countNext = 2'd1;
          end
        end
        default: begin
          w_countNext = 2'd0;
        end
      endcase
    end
  end

  // State registers, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_count <= w_countNext;
      r_head  <= w_headNext;
      r_tail  <= w_tailNext;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: a driver pushes expected beats into a
// queue, and a negedge monitor compares the DUT head against the queue head.
module tb_alu_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1_addr;
  logic [31:0] in_rs1_data;
  logic [4:0]  in_rs2_addr;
  logic [31:0] in_rs2_data;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [1:0]  in_sel;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data1;
  logic [31:0] out_data2;
  logic [1:0]  out_sel;
  logic [4:0]  out_rd;
  logic        out_reg_write;

  typedef struct {
    logic [4:0]  rs1Addr;
    logic [31:0] op1;
    logic [4:0]  rs2Addr;
    logic [31:0] op2;
    logic        useImm;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        regWrite;
  } beat_t;

  beat_t expQ[$];
  int    nVectors = 0;
  int    nMiss = 0;
  bit    monEnable = 0;
  bit    accReady = 0;
  bit    gotIt;

  alu_operand_stage #(.WIDTH(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs1_data(in_rs1_data),
    .in_rs2_addr(in_rs2_addr), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_sel(in_sel),
    .in_rd(in_rd), .in_reg_write(in_reg_write),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data1(out_data1), .out_data2(out_data2), .out_sel(out_sel),
    .out_rd(out_rd), .out_reg_write(out_reg_write)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model of a writeback hitting a register source (x0 never hit).
  function automatic bit wbHits(input logic [4:0] addr);
    return wb_en && (wb_addr != 5'd0) && (wb_addr == addr);
  endfunction

  // Drive one cycle of inputs; once the monitor has judged in_ready, queue the expected beat.
  task automatic applyStimulus(input bit v, input logic [4:0] a1, input logic [31:0] d1,
                               input logic [4:0] a2, input logic [31:0] d2,
                               input logic [31:0] imm, input bit useImm, input logic [1:0] sel,
                               input logic [4:0] rd, input bit rw, input bit ordy, input bit fl,
                               input bit we, input logic [4:0] wa, input logic [31:0] wd,
                               output bit accepted);
    beat_t b;
    @(posedge clk);
    #1;
    in_valid = v; in_rs1_addr = a1; in_rs1_data = d1; in_rs2_addr = a2; in_rs2_data = d2;
    in_imm = imm; in_use_imm = useImm; in_sel = sel; in_rd = rd; in_reg_write = rw;
    out_ready = ordy; flush = fl; wb_en = we; wb_addr = wa; wb_data = wd;
    #5;
    accepted = v && accReady;
    if (accepted) begin
      b.rs1Addr = a1;
      b.op1 = wbHits(a1) ? wd : d1;
      b.rs2Addr = a2;
      b.op2 = useImm ? imm : (wbHits(a2) ? wd : d2);
      b.useImm = useImm;
      b.sel = sel;
      b.rd = rd;
      b.regWrite = rw;
      expQ.push_back(b);
    end
  endtask

  task automatic idle(input bit ordy, input bit we, input logic [4:0] wa, input logic [31:0] wd);
    bit acc;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ordy, 0, we, wa, wd, acc);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_data1"}, out_data1, 32'd0);
    checkOutput({tag, "_data2"}, out_data2, 32'd0);
    checkOutput({tag, "_sel"}, 32'(out_sel), 32'd0);
    checkOutput({tag, "_rd"}, 32'(out_rd), 32'd0);
    checkOutput({tag, "_regwr"}, 32'(out_reg_write), 32'd0);
  endtask

  // Monitor: mid-cycle, compare DUT against the model, then advance the model across the coming edge.
  always @(negedge clk) begin
    if (monEnable) begin
      accReady = (expQ.size() < 2) && !flush;
      checkOutput("in_ready", 32'(in_ready), 32'(accReady));
      checkOutput("out_valid", 32'(out_valid), 32'(expQ.size() != 0));
      if (expQ.size() != 0) begin
        checkOutput("data1", out_data1, expQ[0].op1);
        checkOutput("data2", out_data2, expQ[0].op2);
        checkOutput("sel", 32'(out_sel), 32'(expQ[0].sel));
        checkOutput("rd", 32'(out_rd), 32'(expQ[0].rd));
        checkOutput("reg_write", 32'(out_reg_write), 32'(expQ[0].regWrite));
      end
      if (flush) begin
        expQ.delete();
      end else begin
        if ((expQ.size() != 0) && out_ready) begin
          void'(expQ.pop_front());
        end
        foreach (expQ[i]) begin
          if (wbHits(expQ[i].rs1Addr)) expQ[i].op1 = wb_data;
          if (!expQ[i].useImm && wbHits(expQ[i].rs2Addr)) expQ[i].op2 = wb_data;
        end
      end
    end
  end

  initial begin
    bit acc;
    rst_n = 1'b0; in_valid = 0; in_rs1_addr = 0; in_rs1_data = 0; in_rs2_addr = 0;
    in_rs2_data = 0; in_imm = 0; in_use_imm = 0; in_sel = 0; in_rd = 0; in_reg_write = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0; flush = 0; out_ready = 0;
    #2;
    checkAllZero("reset");
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    #10;
    rst_n = 1'b1;
    monEnable = 1;

    // Plain add beat: 5 and 7 presented one cycle later.
    applyStimulus(1, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 0, 2'b00, 5'd3, 1, 1, 0, 0, 0, 0, acc);
    idle(1, 0, 0, 0);

    // Capture forwarding, then the same case against x0.
    applyStimulus(1, 5'd3, 32'd1, 5'd6, 32'd2, 32'd0, 0, 2'b01, 5'd4, 1, 1, 0, 1, 5'd3, 32'hAA, acc);
    idle(1, 0, 0, 0);
    applyStimulus(1, 5'd0, 32'd1, 5'd6, 32'd2, 32'd0, 0, 2'b10, 5'd4, 0, 1, 0, 1, 5'd0, 32'hAA, acc);
    idle(1, 0, 0, 0);

    // Snoop into a held register operand, then an immediate that must not change.
    applyStimulus(1, 5'd1, 32'd1, 5'd4, 32'd2, 32'd0, 0, 2'b00, 5'd5, 1, 0, 0, 0, 0, 0, acc);
    idle(0, 1, 5'd4, 32'd9);
    idle(1, 0, 0, 0);
    applyStimulus(1, 5'd1, 32'd1, 5'd4, 32'd2, 32'd6, 1, 2'b11, 5'd5, 1, 0, 0, 0, 0, 0, acc);
    idle(0, 1, 5'd4, 32'd9);
    idle(1, 0, 0, 0);

    // Backpressure: three beats offered to a stalled stage, the third held until taken.
    applyStimulus(1, 5'd8, 32'h11, 5'd9, 32'h21, 0, 0, 2'b00, 5'd1, 1, 0, 0, 0, 0, 0, acc);
    applyStimulus(1, 5'd8, 32'h12, 5'd9, 32'h22, 0, 0, 2'b01, 5'd2, 1, 0, 0, 0, 0, 0, acc);
    applyStimulus(1, 5'd8, 32'h13, 5'd9, 32'h23, 0, 0, 2'b10, 5'd3, 1, 0, 0, 0, 0, 0, acc);
    checkOutput("third_beat_rejected", 32'(acc), 32'd0);
    gotIt = 0;
    for (int t = 0; t < 8 && !gotIt; t++) begin
      applyStimulus(1, 5'd8, 32'h13, 5'd9, 32'h23, 0, 0, 2'b10, 5'd3, 1, 1, 0, 0, 0, 0, acc);
      gotIt = acc;
    end
    checkOutput("third_beat_taken", 32'(gotIt), 32'd1);
    idle(1, 0, 0, 0);
    idle(1, 0, 0, 0);

    // Flush while full with a beat offered: everything disappears.
    applyStimulus(1, 5'd2, 32'h31, 5'd3, 32'h41, 0, 0, 2'b00, 5'd1, 1, 0, 0, 0, 0, 0, acc);
    applyStimulus(1, 5'd2, 32'h32, 5'd3, 32'h42, 0, 0, 2'b00, 5'd1, 1, 0, 0, 0, 0, 0, acc);
    applyStimulus(1, 5'd2, 32'h33, 5'd3, 32'h43, 0, 0, 2'b00, 5'd1, 1, 0, 1, 0, 0, 0, acc);
    idle(1, 0, 0, 0);

    // Reset in the middle of a held beat clears outputs without waiting for a clock.
    applyStimulus(1, 5'd7, 32'h55, 5'd6, 32'h66, 0, 0, 2'b11, 5'd9, 1, 0, 0, 0, 0, 0, acc);
    @(posedge clk);
    #1;
    in_valid = 0; flush = 0; wb_en = 0; out_ready = 0;
    checkOutput("held_before_reset", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkAllZero("midreset");
    #5;
    rst_n = 1'b1;

    // Randomized traffic with a small register space so forwarding hits often.
    for (int n = 0; n < 1500; n++) begin
      applyStimulus($urandom_range(0, 9) < 7,
                    5'($urandom_range(0, 7)), $urandom(),
                    5'($urandom_range(0, 7)), $urandom(),
                    $urandom(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(), acc);
    end

    // Drain, so the model and the DUT must both end empty.
    for (int n = 0; n < 4; n++) idle(1, 0, 0, 0);
    checkOutput("drained", 32'(expQ.size()), 32'd0);

    @(posedge clk);
    #1;
    monEnable = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end

endmodule
